// File: rtl/pool_a2_cu_if.sv
// Handshake and memory-strobe bundle between pooling control unit A2,
// conv stage A1 output memory, the pooling datapath and the next layer.
interface pool_a2_cu_if #(
  parameter int AW_IFM  = 10,
  parameter int AW_NEXT = 11
);
  logic               start_from_previous;
  logic               end_to_previous;
  logic               ifm_enable_read;
  logic [AW_IFM-1:0]  ifm_address_read;
  logic               ifm_sel_read;
  logic               pool_clear;
  logic               pool_enable;
  logic               ifm_enable_write_next;
  logic [AW_NEXT-1:0] ifm_address_write_next;
  logic               end_from_next;
  logic               start_to_next;
  logic               ready;

  modport master (
    input  start_from_previous,
    input  end_from_next,
    output end_to_previous,
    output ifm_enable_read,
    output ifm_address_read,
    output ifm_sel_read,
    output pool_clear,
    output pool_enable,
    output ifm_enable_write_next,
    output ifm_address_write_next,
    output start_to_next,
    output ready
  );

  modport slave (
    output start_from_previous,
    output end_from_next,
    input  end_to_previous,
    input  ifm_enable_read,
    input  ifm_address_read,
    input  ifm_sel_read,
    input  pool_clear,
    input  pool_enable,
    input  ifm_enable_write_next,
    input  ifm_address_write_next,
    input  start_to_next,
    input  ready
  );
endinterface

// File: rtl/pool_a2_cu.sv
// Control unit for 2x2/stride-2 pooling stage A2: walks each A1 map
// window by window, strobes the max datapath and writes pooled maps.
module pool_a2_cu #(
  parameter int IFM_SIZE          = 28,
  parameter int IFM_DEPTH         = 6,
  parameter int IFM_SIZE_NEXT     = IFM_SIZE / 2,
  parameter int ADDRESS_SIZE_IFM  = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT =
    $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT * IFM_DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  pool_a2_cu_if.master io
);

  localparam int CW = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT) : 1;
  localparam int MW = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
  localparam int AW = ADDRESS_SIZE_IFM;
  localparam int NW = ADDRESS_SIZE_NEXT;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    HANDOFF
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    elem_q, elem_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          drain_q, drain_d;
  logic [MW-1:0] map_q, map_d;
  logic          sel_q, sel_d;
  logic [NW-1:0] waddr_q, waddr_d;
  logic          pen_q, pen_d;
  logic          pclr_q, pclr_d;
  logic          w1_q, w1_d;
  logic          we_q, we_d;

  logic          rd_en;
  logic          stn;
  logic          waddr_clr;
  logic          last_elem;
  logic          last_col;
  logic          last_row;
  logic [AW-1:0] raddr;
  logic [AW-1:0] row_w;
  logic [AW-1:0] col_w;

  assign last_elem = (elem_q == 2'd3);
  assign last_col  = (col_q == CW'(IFM_SIZE_NEXT - 1));
  assign last_row  = (row_q == CW'(IFM_SIZE_NEXT - 1));

  // Window-major walk: top-left, top-right, bottom-left, bottom-right
  always_comb begin
    row_w = AW'(row_q);
    col_w = AW'(col_q);
    raddr = ((row_w << 1) + AW'(elem_q[1])) * AW'(IFM_SIZE)
          + (col_w << 1) + AW'(elem_q[0]);
  end

  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    col_d     = col_q;
    row_d     = row_q;
    drain_d   = drain_q;
    map_d     = map_q;
    sel_d     = sel_q;
    rd_en     = 1'b0;
    stn       = 1'b0;
    waddr_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (io.start_from_previous) begin
          state_d = READ;
        end
      end
      READ: begin
        rd_en  = 1'b1;
        elem_d = elem_q + 2'd1;
        if (last_elem) begin
          col_d = last_col ? '0 : col_q + 1'b1;
          if (last_col) begin
            row_d = last_row ? '0 : row_q + 1'b1;
            if (last_row) begin
              state_d = DRAIN;
              drain_d = 1'b0;
            end
          end
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          drain_d = 1'b0;
          sel_d   = ~sel_q;
          map_d   = map_q + 1'b1;
          if (map_q == MW'(IFM_DEPTH - 1)) begin
            state_d = HANDOFF;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HANDOFF: begin
        if (io.end_from_next) begin
          stn       = 1'b1;
          map_d     = '0;
          waddr_clr = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath strobes trail the read by the memory latency;
  // the write waits one more cycle for the max to settle.
  always_comb begin
    pen_d   = rd_en;
    pclr_d  = rd_en & (elem_q == 2'd0);
    w1_d    = rd_en & last_elem;
    we_d    = w1_q;
    waddr_d = waddr_clr ? '0 : waddr_q + NW'(we_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      elem_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= 1'b0;
      map_q   <= '0;
      sel_q   <= 1'b0;
      waddr_q <= '0;
      pen_q   <= 1'b0;
      pclr_q  <= 1'b0;
      w1_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      col_q   <= col_d;
      row_q   <= row_d;
      drain_q <= drain_d;
      map_q   <= map_d;
      sel_q   <= sel_d;
      waddr_q <= waddr_d;
      pen_q   <= pen_d;
      pclr_q  <= pclr_d;
      w1_q    <= w1_d;
      we_q    <= we_d;
    end
  end

  assign io.end_to_previous        = (state_q == IDLE);
  assign io.ready                  = (state_q == IDLE);
  assign io.ifm_enable_read        = rd_en;
  assign io.ifm_address_read       = raddr;
  assign io.ifm_sel_read           = sel_q;
  assign io.pool_enable            = pen_q;
  assign io.pool_clear             = pclr_q;
  assign io.ifm_enable_write_next  = we_q;
  assign io.ifm_address_write_next = waddr_q;
  assign io.start_to_next          = stn;

endmodule

// File: tb/tb_pool_a2_cu.sv
// Bench for pool_a2_cu: A1 memory and max-pool datapath models,
// directed frame sequence with randomized map contents.
module tb_pool_a2_cu;

  localparam int N    = 28;
  localparam int NN   = 14;
  localparam int D    = 6;
  localparam int RD   = N * N;
  localparam int MAPW = NN * NN;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pool_a2_cu_if bus ();

  pool_a2_cu dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.master)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A1 memory (1-cycle read), max datapath, next-layer memory
  logic [15:0] mem [2][RD];
  logic [15:0] omem [D*MAPW];
  logic [15:0] mdq;
  logic [15:0] acc;

  always @(posedge clk) begin
    if (bus.ifm_enable_read)
      mdq <= mem[bus.ifm_sel_read][bus.ifm_address_read];
    if (bus.pool_enable)
      acc <= bus.pool_clear ? mdq : ((mdq > acc) ? mdq : acc);
    if (bus.ifm_enable_write_next)
      omem[bus.ifm_address_write_next] <= acc;
  end

  int cyc = 0;
  int rd_n, wr_n, en_n, clr_n, bad_t, last_wr_cyc;
  int st_n = 0;
  int st_cyc = 0;
  int rd_addr[$];
  int rd_sel[$];
  int wr_addr[$];
  int q4[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.ifm_enable_read) begin
      rd_addr.push_back(int'(bus.ifm_address_read));
      rd_sel.push_back(int'(bus.ifm_sel_read));
      if (rd_n % 4 == 3) q4.push_back(cyc);
      rd_n++;
    end
    if (bus.pool_enable) en_n++;
    if (bus.pool_clear) clr_n++;
    if (bus.ifm_enable_write_next) begin
      wr_addr.push_back(int'(bus.ifm_address_write_next));
      last_wr_cyc = cyc;
      if (q4.size() == 0) bad_t++;
      else if (cyc - q4.pop_front() != 2) bad_t++;
      wr_n++;
    end
    if (bus.start_to_next) begin
      st_n++;
      st_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_addr.delete();
    rd_sel.delete();
    wr_addr.delete();
    q4.delete();
    rd_n = 0; wr_n = 0; en_n = 0; clr_n = 0; bad_t = 0;
  endtask

  task automatic pulse_start();
    bus.start_from_previous = 1'b1;
    tick();
    bus.start_from_previous = 1'b0;
  endtask

  function automatic int exp_addr(input int k);
    int w, e, r, c;
    w = k / 4; e = k % 4; r = w / NN; c = w % NN;
    return (2 * r + e / 2) * N + 2 * c + e % 2;
  endfunction

  function automatic logic [15:0] exp_max(input int bank, input int w);
    logic [15:0] m;
    int r, c;
    r = w / NN; c = w % NN;
    m = 0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (mem[bank][(2*r+dr)*N + 2*c+dc] > m)
          m = mem[bank][(2*r+dr)*N + 2*c+dc];
    return m;
  endfunction

  task automatic fill(input int bank, input bit pattern);
    for (int k = 0; k < RD; k++)
      mem[bank][k] = pattern ? 16'(k) : 16'($urandom_range(0, 65535));
  endtask

  // One map: start, optional stray starts, then check reads/writes
  task automatic run_map(input int m, input int bank,
                         input bit pattern, input bit inject);
    int err_a, err_s, err_w, err_d;
    fill(bank, pattern);
    clear_logs();
    chk($sformatf("ready_m%0d", m), bus.ready, 1);
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      bus.start_from_previous =
        inject && (i == 100 || i == 784 || i == 785);
      tick();
      if (wr_n == MAPW) break;
    end
    bus.start_from_previous = 1'b0;
    chk($sformatf("wr_count_m%0d", m), wr_n, MAPW);
    chk($sformatf("rd_count_m%0d", m), rd_n, RD);
    err_a = 0; err_s = 0; err_w = 0; err_d = 0;
    for (int k = 0; k < rd_addr.size(); k++) begin
      if (rd_addr[k] != exp_addr(k)) err_a++;
      if (rd_sel[k] != bank) err_s++;
    end
    for (int w = 0; w < wr_addr.size(); w++)
      if (wr_addr[w] != m * MAPW + w) err_w++;
    for (int w = 0; w < MAPW; w++)
      if (omem[m * MAPW + w] !== exp_max(bank, w)) err_d++;
    chk($sformatf("rd_order_m%0d", m), err_a, 0);
    chk($sformatf("rd_bank_m%0d", m), err_s, 0);
    chk($sformatf("pool_en_m%0d", m), en_n, RD);
    chk($sformatf("pool_clr_m%0d", m), clr_n, MAPW);
    chk($sformatf("wr_timing_m%0d", m), bad_t, 0);
    chk($sformatf("wr_addr_m%0d", m), err_w, 0);
    chk($sformatf("wr_data_m%0d", m), err_d, 0);
    chk($sformatf("sel_after_m%0d", m), bus.ifm_sel_read, (bank + 1) % 2);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, bus.ready, 1);
    chk({tag, "_end_prev"}, bus.end_to_previous, 1);
    chk({tag, "_rd_en"}, bus.ifm_enable_read, 0);
    chk({tag, "_rd_addr"}, bus.ifm_address_read, 0);
    chk({tag, "_sel"}, bus.ifm_sel_read, 0);
    chk({tag, "_pool_en"}, bus.pool_enable, 0);
    chk({tag, "_pool_clr"}, bus.pool_clear, 0);
    chk({tag, "_we"}, bus.ifm_enable_write_next, 0);
    chk({tag, "_waddr"}, bus.ifm_address_write_next, 0);
    chk({tag, "_stn"}, bus.start_to_next, 0);
  endtask

  initial begin
    bus.start_from_previous = 1'b0;
    bus.end_from_next = 1'b0;
    clear_logs();
    repeat (3) tick();
    chk_idle_outputs("reset");
    reset = 1'b1;
    tick();

    // Map 0 with value = address
    run_map(0, 0, 1'b1, 1'b0);
    chk("rd0", rd_addr[0], 0);
    chk("rd1", rd_addr[1], 1);
    chk("rd2", rd_addr[2], 28);
    chk("rd3", rd_addr[3], 29);
    chk("rd4", rd_addr[4], 2);
    chk("rd7", rd_addr[7], 31);
    chk("rd780", rd_addr[780], 754);
    chk("rd783", rd_addr[783], 783);
    chk("pat_00", omem[0], 29);
    chk("pat_10", omem[14], 85);
    chk("pat_last", omem[195], 783);

    for (int m = 1; m < D; m++)
      run_map(m, m % 2, 1'b0, m == 2);
    chk("last_waddr", wr_addr[MAPW-1], D * MAPW - 1);

    // Frame held in HANDOFF until the next stage frees up
    pulse_start();
    repeat (5) tick();
    chk("hold_ready", bus.ready, 0);
    chk("hold_end_prev", bus.end_to_previous, 0);
    chk("hold_rd_en", bus.ifm_enable_read, 0);
    chk("hold_stn_cnt", st_n, 0);
    bus.end_from_next = 1'b1;
    #1;
    chk("stn_level", bus.start_to_next, 1);
    tick();
    bus.end_from_next = 1'b0;
    tick();
    chk("stn_cnt1", st_n, 1);
    chk("ho_ready", bus.ready, 1);
    chk("ho_waddr", bus.ifm_address_write_next, 0);
    chk("ho_sel", bus.ifm_sel_read, 0);

    // Next stage always free: pulse in first HANDOFF cycle
    bus.end_from_next = 1'b1;
    st_n = 0;
    for (int m = 0; m < D; m++)
      run_map(m, m % 2, 1'b0, 1'b0);
    tick();
    tick();
    chk("ef_stn_cnt", st_n, 1);
    chk("ef_stn_cyc", st_cyc, last_wr_cyc + 1);
    chk("ef_ready", bus.ready, 1);
    chk("ef_waddr", bus.ifm_address_write_next, 0);
    bus.end_from_next = 1'b0;

    // Abort map 2 mid-read
    run_map(0, 0, 1'b0, 1'b0);
    run_map(1, 1, 1'b0, 1'b0);
    fill(0, 1'b0);
    clear_logs();
    pulse_start();
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rd_n >= 400) break;
    end
    chk("abort_rd_n", rd_n, 400);
    reset = 1'b0;
    #1;
    chk_idle_outputs("abort");
    tick();
    reset = 1'b1;
    tick();
    run_map(0, 0, 1'b0, 1'b0);
    chk("post_rd0", rd_addr[0], 0);
    chk("post_wr0", wr_addr[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
